argmax_classifier: RTL and testbench

- Final decision stage directly downstream of the last dense layer.
- Latches the vector of ReLU'd neuron outputs (one 32-bit word per class) from the output layer.
- Scans the vector sequentially, one class per cycle, and reports the winning class index and its score.
- Uses a valid/ready handshake, so the upstream layer pipeline can stall when the result is not consumed.

---
 rtl/argmax_pkg.sv | 6 +
 rtl/argmax_cmp_step.sv | 28 ++
 rtl/argmax_classifier.sv | 129 ++++++++++++
 tb/tb_argmax_classifier.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/argmax_pkg.sv
// argmax_pkg: shared state encoding and layer-wide width defaults for the argmax stage.
package argmax_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int NUM_CLASSES_DEF = 5;
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/argmax_cmp_step.sv
// argmax_cmp_step: one signed compare-and-select of a scanned element against the running best.
// ARGMAX_MARGIN_EN adds runner-up tracking.
module argmax_cmp_step
    import argmax_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W = 3
) (
    input  logic [DATA_W-1:0] elem,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] best,
    input  logic [IDX_W-1:0]  best_idx,
`ifdef ARGMAX_MARGIN_EN
    input  logic [DATA_W-1:0] second,
    output logic [DATA_W-1:0] second_nxt,
`endif
    output logic [DATA_W-1:0] best_nxt,
    output logic [IDX_W-1:0]  best_idx_nxt
);
    // Strictly greater only, so ties keep the lower index.
    logic gt;
    assign gt = $signed(elem) > $signed(best);
    assign best_nxt = gt ? elem : best;
    assign best_idx_nxt = gt ? idx : best_idx;
`ifdef ARGMAX_MARGIN_EN
    assign second_nxt = gt ? best : ($signed(elem) > $signed(second) ? elem : second);
`endif
endmodule

// File: rtl/argmax_classifier.sv
// argmax_classifier: latches a layer output vector and scans it one class per cycle for the signed max.
// ARGMAX_MARGIN_EN adds out_margin/out_reject against margin_thresh.
module argmax_classifier
    import argmax_pkg::*;
#(
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int IDX_W = $clog2(NUM_CLASSES)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CLASSES*DATA_W-1:0] in_vec,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [IDX_W-1:0]              out_class,
    output logic [DATA_W-1:0]             out_score,
    output logic                          out_valid,
    input  logic                          out_ready,
`ifdef ARGMAX_MARGIN_EN
    output logic [DATA_W-1:0]             out_margin,
    input  logic [DATA_W-1:0]             margin_thresh,
    output logic                          out_reject,
`endif
    output logic                          busy
);
    state_t state_q, state_d;
    logic [NUM_CLASSES*DATA_W-1:0] vec_q, vec_d;
    logic [IDX_W-1:0] idx_q, idx_d, best_idx_q, best_idx_d, out_class_q, out_class_d, step_idx;
    logic [DATA_W-1:0] best_q, best_d, out_score_q, out_score_d, step_best;
    logic [DATA_W-1:0] elems [NUM_CLASSES];
    always_comb begin
        for (int k = 0; k < NUM_CLASSES; k++) elems[k] = vec_q[k*DATA_W +: DATA_W];
    end
`ifdef ARGMAX_MARGIN_EN
    logic [DATA_W-1:0] second_q, second_d, margin_q, margin_d, step_second;
`endif
    argmax_cmp_step #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_step (
        .elem(elems[idx_q]),
        .idx(idx_q),
        .best(best_q),
        .best_idx(best_idx_q),
`ifdef ARGMAX_MARGIN_EN
        .second(second_q),
        .second_nxt(step_second),
`endif
        .best_nxt(step_best),
        .best_idx_nxt(step_idx)
    );
    always_comb begin
        state_d = state_q;
        vec_d = vec_q;
        idx_d = idx_q;
        best_d = best_q;
        best_idx_d = best_idx_q;
        out_class_d = out_class_q;
        out_score_d = out_score_q;
`ifdef ARGMAX_MARGIN_EN
        second_d = second_q;
        margin_d = margin_q;
`endif
        case (state_q)
            IDLE: if (in_valid) begin
                vec_d = in_vec;
                best_d = in_vec[DATA_W-1:0];
                best_idx_d = '0;
                idx_d = IDX_W'(1);
`ifdef ARGMAX_MARGIN_EN
                // Most negative value, so the first compared element always becomes runner-up.
                second_d = {1'b1, {(DATA_W-1){1'b0}}};
`endif
                state_d = SCAN;
            end
            SCAN: begin
                best_d = step_best;
                best_idx_d = step_idx;
                idx_d = idx_q + 1'b1;
`ifdef ARGMAX_MARGIN_EN
                second_d = step_second;
`endif
                if (idx_q == IDX_W'(NUM_CLASSES-1)) begin
                    state_d = DONE;
                    out_class_d = step_idx;
                    out_score_d = step_best;
`ifdef ARGMAX_MARGIN_EN
                    margin_d = step_best - step_second;
`endif
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            vec_q <= '0;
            idx_q <= '0;
            best_q <= '0;
            best_idx_q <= '0;
            out_class_q <= '0;
            out_score_q <= '0;
`ifdef ARGMAX_MARGIN_EN
            second_q <= '0;
            margin_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            vec_q <= vec_d;
            idx_q <= idx_d;
            best_q <= best_d;
            best_idx_q <= best_idx_d;
            out_class_q <= out_class_d;
            out_score_q <= out_score_d;
`ifdef ARGMAX_MARGIN_EN
            second_q <= second_d;
            margin_q <= margin_d;
`endif
        end
    end
    assign in_ready = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy = state_q != IDLE;
    assign out_class = out_class_q;
    assign out_score = out_score_q;
`ifdef ARGMAX_MARGIN_EN
    assign out_margin = margin_q;
    assign out_reject = out_valid && (margin_q < margin_thresh);
`endif
endmodule

// File: tb/tb_argmax_classifier.sv
// tb_argmax_classifier: directed and randomized checks of argmax_classifier against a loop-based argmax model.
module tb_argmax_classifier;
    localparam int NC = 5;
    localparam int DW = 32;
    localparam int IW = 3;
    logic clk = 0, reset = 1, in_valid = 0, out_ready = 0;
    logic [NC*DW-1:0] in_vec = '0;
    logic in_ready, out_valid, busy;
    logic [IW-1:0] out_class;
    logic [DW-1:0] out_score;
`ifdef ARGMAX_MARGIN_EN
    logic [DW-1:0] out_margin, margin_thresh = 1;
    logic out_reject;
`endif
    int total = 0, passed = 0, cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    argmax_classifier dut (
        .clk(clk), .reset(reset), .in_vec(in_vec), .in_valid(in_valid), .in_ready(in_ready),
        .out_class(out_class), .out_score(out_score), .out_valid(out_valid), .out_ready(out_ready),
`ifdef ARGMAX_MARGIN_EN
        .out_margin(out_margin), .margin_thresh(margin_thresh), .out_reject(out_reject),
`endif
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: first index holding the signed maximum; runner-up is the max of all other entries.
    task automatic model(input logic [NC*DW-1:0] v, output int cls, output logic [DW-1:0] sc, output logic [DW-1:0] mg);
        int sec;
        cls = 0;
        for (int k = 1; k < NC; k++)
            if ($signed(v[k*DW +: DW]) > $signed(v[cls*DW +: DW])) cls = k;
        sec = (cls == 0) ? 1 : 0;
        for (int k = 0; k < NC; k++)
            if (k != cls && $signed(v[k*DW +: DW]) > $signed(v[sec*DW +: DW])) sec = k;
        sc = v[cls*DW +: DW];
        mg = sc - v[sec*DW +: DW];
    endtask

    function automatic logic [NC*DW-1:0] pack(input int a, input int b, input int c, input int d, input int e);
        return {e[DW-1:0], d[DW-1:0], c[DW-1:0], b[DW-1:0], a[DW-1:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        if (!out_valid) chk({tag, "_timeout"}, 0, 1);
    endtask

    task automatic check_result(input string tag, input logic [NC*DW-1:0] v);
        int cls;
        logic [DW-1:0] sc, mg;
        model(v, cls, sc, mg);
        chk({tag, "_class"}, out_class, cls);
        chk({tag, "_score"}, out_score, sc);
`ifdef ARGMAX_MARGIN_EN
        chk({tag, "_margin"}, out_margin, mg);
        chk({tag, "_reject"}, out_reject, mg < margin_thresh);
`endif
    endtask

    task automatic run_vec(input string tag, input logic [NC*DW-1:0] v);
        int n;
        in_vec = v;
        in_valid = 1;
        tick();
        in_valid = 0;
        chk({tag, "_busy"}, busy, 1);
        wait_done(tag, n);
        chk({tag, "_latency"}, n, NC - 1);
        chk({tag, "_in_ready_done"}, in_ready, 0);
        check_result(tag, v);
    endtask

    task automatic release_result(input string tag);
        out_ready = 1;
        tick();
        out_ready = 0;
        chk({tag, "_out_valid_low"}, out_valid, 0);
        chk({tag, "_in_ready_high"}, in_ready, 1);
    endtask

    function automatic logic [NC*DW-1:0] rand_vec();
        logic [NC*DW-1:0] v;
        for (int k = 0; k < NC; k++) begin
            int x;
            x = ($urandom_range(0, 1) == 1) ? int'($urandom) : int'($urandom_range(0, 6)) - 3;
            v[k*DW +: DW] = x;
        end
        return v;
    endfunction

    initial begin
        logic [NC*DW-1:0] v;
        int n, last;
        int cls;
        logic [DW-1:0] sc, mg;
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_class", out_class, 0);
        chk("rst_score", out_score, 0);
        tick();
        reset = 0;
        tick();

        run_vec("tie", pack(10, 50, 30, 50, 20));
        chk("tie_class_lit", out_class, 1);
        chk("tie_score_lit", out_score, 50);
        release_result("tie");

        run_vec("zero", '0);
        chk("zero_class_lit", out_class, 0);
        chk("zero_score_lit", out_score, 0);
`ifdef ARGMAX_MARGIN_EN
        chk("zero_margin_lit", out_margin, 0);
        chk("zero_reject_lit", out_reject, 1);
`endif
        release_result("zero");

        run_vec("neg", pack(-5, -1, -7, -2, -9));
        chk("neg_class_lit", out_class, 1);
        chk("neg_score_lit", out_score, 32'hFFFF_FFFF);
        release_result("neg");

        v = rand_vec();
        run_vec("hold", v);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_vec = rand_vec();
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            check_result("hold", v);
        end
        in_valid = 0;
        release_result("hold");

        in_vec = rand_vec();
        in_valid = 1;
        tick();
        in_valid = 0;
        tick();
        tick();
        chk("mid_scan_busy", busy, 1);
        reset = 1;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_class", out_class, 0);
        #2;
        reset = 0;
        tick();
        run_vec("after_rst", pack(1, 2, 3, 4, 100));
        chk("after_rst_class_lit", out_class, 4);
        chk("after_rst_score_lit", out_score, 100);
        release_result("after_rst");

        out_ready = 1;
        in_valid = 1;
        last = -1;
        for (int i = 0; i < 12; i++) begin
            v = rand_vec();
            in_vec = v;
            wait_done("b2b", n);
            check_result("b2b", v);
            if (last >= 0) chk("b2b_period", cyc - last, NC + 1);
            last = cyc;
            tick();
            chk("b2b_in_ready", in_ready, 1);
        end
        in_valid = 0;
        out_ready = 0;
        model(pack(7, 7, 7, 7, 7), cls, sc, mg);
        run_vec("flat", pack(7, 7, 7, 7, 7));
        chk("flat_class_lit", cls, 0);
        release_result("flat");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
